mont_modexp_seq: RTL
====================

// Module: mont_modexp_seq
// PURPOSE
//  Sequencer for modular exponentiation, result = base^exponent mod n, by left-to-right square-and-multiply.
//  Sits directly upstream of the Montgomery multiplier and drives one external instance of it through
//  the mm_* ports: operands out, result and done back.
//  Handles conversion into the Montgomery domain (MM(base,R2)) and back out (MM(acc,1)).
//  Paillier encryption and decryption build on it: g^m, r^n and L(c^lambda) mod n^2.
// PARAMETERS
//  WIDTH      1024  modulus and operand width; R = 2^WIDTH
//  EXP_WIDTH  1024  exponent width
// PORTS
//  clk         in   1          clock, rising edge
//  rst         in   1          synchronous, active-high reset
//  start       in   1          1-cycle request; sampled only in IDLE
//  base        in   WIDTH      base in normal domain, must be < n
//  exponent    in   EXP_WIDTH  exponent
//  n           in   WIDTH      odd modulus, n > 1
//  n_prime     in   WIDTH      -n^-1 mod R
//  r_mod_n     in   WIDTH      R mod n (Montgomery one)
//  r2_mod_n    in   WIDTH      R^2 mod n
//  busy        out  1          high from the cycle after an accepted start until done
//  done        out  1          1-cycle pulse; result valid in the same cycle
//  result      out  WIDTH      base^exponent mod n; held until the next accepted start
//  mm_start    out  1          1-cycle pulse to the multiplier
//  mm_a        out  WIDTH      multiplier operand a; stable from mm_start until mm_done
//  mm_b        out  WIDTH      multiplier operand b; stable from mm_start until mm_done
//  mm_n        out  WIDTH      latched n
//  mm_n_prime  out  WIDTH      latched n_prime
//  mm_result   in   WIDTH      multiplier result
//  mm_done     in   1          multiplier completion; sampled only in WAIT
// BEHAVIOUR
//  Reset: busy=0, done=0, result=0, mm_start=0, mm_a=mm_b=0; state=IDLE; operand registers cleared.
//  Start handshake:
//   - start in IDLE latches every input; busy rises the next cycle.
//   - start while busy is ignored; inputs may change freely after acceptance.
//  Multiplier handshake:
//   - Each operation = ISSUE (mm_start=1 for exactly one cycle) then WAIT (mm_start=0) until mm_done=1.
//   - mm_result is captured on the cycle mm_done is seen.
//   - The next ISSUE is no earlier than the cycle after mm_done.
//   - Only one operation is outstanding at any time.
//  States:
//   - IDLE    : start -> TOMONT.
//   - TOMONT  : xb = MM(base, r2_mod_n); acc = r_mod_n; bit index i = EXP_WIDTH-1; -> SCAN.
//   - SCAN    : one cycle per bit while exponent[i]==0 and i>0; i-- each cycle.
//               exponent[i]==1 -> SQR. i==0 with bit 0 clear -> FROMMONT (acc stays Montgomery one).
//   - SQR     : acc = MM(acc, acc); -> MUL if exponent[i]==1, else NEXT.
//   - MUL     : acc = MM(acc, xb); -> NEXT.
//   - NEXT    : i==0 -> FROMMONT; else i--, -> SQR.
//   - FROMMONT: result = MM(acc, 1); -> DONE.
//   - DONE    : done=1 for 1 cycle; busy falls in the same cycle; -> IDLE.
//  Arithmetic:
//   - All MM results are < n, so no extra reduction is needed.
//   - exponent==0 gives result 1. base==0 with exponent>0 gives result 0.
//  Bit index i: width $clog2(EXP_WIDTH); it never wraps, because the i==0 test happens before any decrement.
//  Operation count (default build) = 2 + (msb_pos+1) + popcount(exponent); 2 when exponent==0.
//  Reset mid-operation: abort within the reset cycle; no done; mm_start low. The external multiplier shares rst.
// CONFIGURATION
//  MODEXP_CONST_TIME_EN
//   - Defined:
//     - SCAN is bypassed; all EXP_WIDTH bits are processed, one SQR and one MUL per bit.
//     - For a 0 bit, MUL computes MM(acc, xb) into a dummy register and acc is unchanged.
//     - Operation count is fixed at 2 + 2*EXP_WIDTH, independent of exponent.
//     - Timing is data-independent given a fixed-latency multiplier.
//   - Undefined: leading-zero skip and conditional multiply, exactly as described above.
// TESTING
//  Setup: WIDTH=8, EXP_WIDTH=8, n=13, n_prime=59, r_mod_n=9, r2_mod_n=3; behavioural MM model with
//  randomized 1-6 cycle done latency. Check that mm_a/mm_b stay stable until mm_done.
//  T1 base=2, exponent=10 -> result=10, one done pulse; default build issues 8 mm_start pulses.
//  T2 base=5, exponent=0 -> result=1; base=0, exponent=5 -> result=0.
//  T3 base=7, exponent=12 -> result=1 (Fermat); base=3, exponent=1 -> result=3.
//  T4 MODEXP_CONST_TIME_EN: T1 and T3 stimulus -> same results, exactly 18 mm_start pulses each.
//  T5 start pulsed while busy, with different inputs -> ignored; first result unchanged; one done pulse.
//  T6 rst asserted mid-WAIT -> next cycle busy=0, done=0, result=0; a fresh start afterwards computes correctly.

Source files
------------

// File: rtl/mont_modexp_seq.sv
// Left-to-right square-and-multiply sequencer driving an external Montgomery multiplier.
// Optional feature macro: MODEXP_CONST_TIME_EN (fixed SQR+MUL per exponent bit, no leading-zero skip).
module mont_modexp_seq #(
    parameter int unsigned WIDTH     = 1024,
    parameter int unsigned EXP_WIDTH = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     base,
    input  logic [EXP_WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0]     n,
    input  logic [WIDTH-1:0]     n_prime,
    input  logic [WIDTH-1:0]     r_mod_n,
    input  logic [WIDTH-1:0]     r2_mod_n,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    output logic                 mm_start,
    output logic [WIDTH-1:0]     mm_a,
    output logic [WIDTH-1:0]     mm_b,
    output logic [WIDTH-1:0]     mm_n,
    output logic [WIDTH-1:0]     mm_n_prime,
    input  logic [WIDTH-1:0]     mm_result,
    input  logic                 mm_done
);

    localparam int unsigned IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_TOMONT,
        ST_SCAN,
        ST_SQR,
        ST_MUL,
        ST_NEXT,
        ST_FROMMONT,
        ST_WAIT,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_TOMONT,
        OP_SQR,
        OP_MUL,
        OP_FROMMONT
    } op_t;

    state_t               state_q, state_d;
    op_t                  op_q, op_d;
    logic [IW-1:0]        i_q, i_d;
    logic [EXP_WIDTH-1:0] exp_q, exp_d;
    logic [WIDTH-1:0]     base_q, base_d;
    logic [WIDTH-1:0]     r2_q, r2_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     xb_q, xb_d;
`ifdef MODEXP_CONST_TIME_EN
    logic [WIDTH-1:0]     dummy_q, dummy_d;
`endif
    logic                 busy_d, done_d, mm_start_d;
    logic [WIDTH-1:0]     result_d, mm_a_d, mm_b_d, mm_n_d, mm_n_prime_d;
    logic                 bit_c;

    assign bit_c = exp_q[i_q];

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_TOMONT;
            i_q        <= '0;
            exp_q      <= '0;
            base_q     <= '0;
            r2_q       <= '0;
            acc_q      <= '0;
            xb_q       <= '0;
`ifdef MODEXP_CONST_TIME_EN
            dummy_q    <= '0;
`endif
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            mm_start   <= 1'b0;
            mm_a       <= '0;
            mm_b       <= '0;
            mm_n       <= '0;
            mm_n_prime <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            i_q        <= i_d;
            exp_q      <= exp_d;
            base_q     <= base_d;
            r2_q       <= r2_d;
            acc_q      <= acc_d;
            xb_q       <= xb_d;
`ifdef MODEXP_CONST_TIME_EN
            dummy_q    <= dummy_d;
`endif
            busy       <= busy_d;
            done       <= done_d;
            result     <= result_d;
            mm_start   <= mm_start_d;
            mm_a       <= mm_a_d;
            mm_b       <= mm_b_d;
            mm_n       <= mm_n_d;
            mm_n_prime <= mm_n_prime_d;
        end
    end

    // Next-state, operand issue and result capture
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        i_d          = i_q;
        exp_d        = exp_q;
        base_d       = base_q;
        r2_d         = r2_q;
        acc_d        = acc_q;
        xb_d         = xb_q;
`ifdef MODEXP_CONST_TIME_EN
        dummy_d      = dummy_q;
`endif
        busy_d       = busy;
        done_d       = 1'b0;
        result_d     = result;
        mm_start_d   = 1'b0;
        mm_a_d       = mm_a;
        mm_b_d       = mm_b;
        mm_n_d       = mm_n;
        mm_n_prime_d = mm_n_prime;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    exp_d        = exponent;
                    base_d       = base;
                    r2_d         = r2_mod_n;
                    acc_d        = r_mod_n;
                    mm_n_d       = n;
                    mm_n_prime_d = n_prime;
                    busy_d       = 1'b1;
                    state_d      = ST_TOMONT;
                end
            end
            ST_TOMONT: begin
                mm_a_d     = base_q;
                mm_b_d     = r2_q;
                mm_start_d = 1'b1;
                op_d       = OP_TOMONT;
                state_d    = ST_WAIT;
            end
            ST_SCAN: begin
                if (bit_c) begin
                    state_d = ST_SQR;
                end else if (i_q == '0) begin
                    state_d = ST_FROMMONT;
                end else begin
                    i_d = i_q - IW'(1);
                end
            end
            ST_SQR: begin
                mm_a_d     = acc_q;
                mm_b_d     = acc_q;
                mm_start_d = 1'b1;
                op_d       = OP_SQR;
                state_d    = ST_WAIT;
            end
            ST_MUL: begin
                mm_a_d     = acc_q;
                mm_b_d     = xb_q;
                mm_start_d = 1'b1;
                op_d       = OP_MUL;
                state_d    = ST_WAIT;
            end
            ST_NEXT: begin
                if (i_q == '0) begin
                    state_d = ST_FROMMONT;
                end else begin
                    i_d     = i_q - IW'(1);
                    state_d = ST_SQR;
                end
            end
            ST_FROMMONT: begin
                mm_a_d     = acc_q;
                mm_b_d     = WIDTH'(1);
                mm_start_d = 1'b1;
                op_d       = OP_FROMMONT;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (mm_done) begin
                    case (op_q)
                        OP_TOMONT: begin
                            xb_d = mm_result;
                            i_d  = IW'(EXP_WIDTH - 1);
`ifdef MODEXP_CONST_TIME_EN
                            state_d = ST_SQR;
`else
                            state_d = ST_SCAN;
`endif
                        end
                        OP_SQR: begin
                            acc_d = mm_result;
`ifdef MODEXP_CONST_TIME_EN
                            state_d = ST_MUL;
`else
                            state_d = bit_c ? ST_MUL : ST_NEXT;
`endif
                        end
                        OP_MUL: begin
`ifdef MODEXP_CONST_TIME_EN
                            if (bit_c) begin
                                acc_d = mm_result;
                            end else begin
                                dummy_d = mm_result;
                            end
`else
                            acc_d = mm_result;
`endif
                            state_d = ST_NEXT;
                        end
                        OP_FROMMONT: begin
                            result_d = mm_result;
                            done_d   = 1'b1;
                            busy_d   = 1'b0;
                            state_d  = ST_DONE;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
